wait_timer_arbiter: RTL

WAIT_TIMER_ARBITER -- requirements
Module: wait_timer_arbiter

---
 rtl/wait_timer_arbiter_pkg.sv | 15 +
 rtl/wait_timer_arbiter_rr_pick.sv | 32 +++
 rtl/wait_timer_arbiter.sv | 96 +++++++++
 3 files changed

// File: rtl/wait_timer_arbiter_pkg.sv
// Shared types and default constants for the round-robin wait timer arbiter.
// The FSM encoding lives here so the top and any checker see the same values.
package wait_timer_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam int          N_REQ_DEF     = 4;
    localparam int          CNT_W_DEF     = 24;
    localparam logic [23:0] DEF_DELAY_DEF = 24'd10000000;

endpackage

// File: rtl/wait_timer_arbiter_rr_pick.sv
// Round-robin selector: first set req bit searching upward from last_id+1 with wrap.
// Purely combinational; the caller registers the result.
module rr_pick
    import wait_timer_arbiter_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last_id,
    output logic             valid,
    output logic [ID_W-1:0]  idx
);

    int j;

    // Scan farthest-first so the nearest candidate after last_id overwrites the rest.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        j     = 0;
        for (int i = N_REQ; i >= 1; i--) begin
            j = int'(last_id) + i;
            if (j >= N_REQ) j = j - N_REQ;
            if (req[j]) begin
                valid = 1'b1;
                idx   = j[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/wait_timer_arbiter.sv
// Shared wait timer: grants one requester at a time a delay-cycle countdown,
// pulses done to the owner on expiry, and aborts if the owner drops its request.
module wait_timer_arbiter
    import wait_timer_arbiter_pkg::*;
#(
    parameter int               N_REQ     = N_REQ_DEF,
    parameter int               CNT_W     = CNT_W_DEF,
    parameter logic [CNT_W-1:0] DEF_DELAY = CNT_W'(DEF_DELAY_DEF)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic                     cfg_we,
    input  logic [CNT_W-1:0]         cfg_delay,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         done,
    output logic                     busy,
    output logic [$clog2(N_REQ)-1:0] cur_id
);

    localparam int              ID_W     = $clog2(N_REQ);
    localparam logic [ID_W-1:0] LAST_RST = ID_W'(N_REQ - 1);

    state_e           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, delay;
    logic [ID_W-1:0]  last_id, last_id_nxt, cur_id_nxt, pick_idx;
    logic [N_REQ-1:0] gnt_nxt, done_nxt;
    logic             busy_nxt, pick_valid, abort;

    rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
        .req     (req),
        .last_id (last_id),
        .valid   (pick_valid),
        .idx     (pick_idx)
    );

    assign abort = (state == ST_COUNT) && !req[cur_id];

    // State, counter, bookkeeping and all outputs are registered together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            last_id <= LAST_RST;
            cur_id  <= '0;
            gnt     <= '0;
            done    <= '0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            last_id <= last_id_nxt;
            cur_id  <= cur_id_nxt;
            gnt     <= gnt_nxt;
            done    <= done_nxt;
            busy    <= busy_nxt;
        end
    end

    // Delay is frozen outside IDLE, so a running COUNT always sees the value it started with.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            delay <= DEF_DELAY;
        end else if (state == ST_IDLE && cfg_we) begin
            delay <= (cfg_delay == '0) ? CNT_W'(1) : cfg_delay;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (pick_valid) state_nxt = ST_COUNT;
            ST_COUNT: begin
                if (abort)                         state_nxt = ST_IDLE;
                else if (cnt == delay - CNT_W'(1)) state_nxt = ST_DONE;
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        gnt_nxt     = '0;
        done_nxt    = '0;
        cnt_nxt     = '0;
        cur_id_nxt  = cur_id;
        last_id_nxt = last_id;
        busy_nxt    = (state_nxt != ST_IDLE);
        if (state == ST_IDLE && pick_valid) cur_id_nxt = pick_idx;
        if (state == ST_COUNT && state_nxt == ST_COUNT) cnt_nxt = cnt + CNT_W'(1);
        if (state_nxt == ST_COUNT || state_nxt == ST_DONE) gnt_nxt[cur_id_nxt] = 1'b1;
        if (state_nxt == ST_DONE) done_nxt[cur_id_nxt] = 1'b1;
        if (state == ST_DONE || abort) last_id_nxt = cur_id;
    end

endmodule
